// File: rtl/mem_access_pkg.sv
// Shared core package: control-unit state constants and the memory-stage FSM encoding.
package mem_access_pkg;

    localparam logic [2:0] CU_FETCH  = 3'd0;
    localparam logic [2:0] CU_DECODE = 3'd1;
    localparam logic [2:0] CU_EXEC   = 3'd2;
    localparam logic [2:0] CU_MEM    = 3'd3;
    localparam logic [2:0] CU_WB     = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } mem_state_e;

endpackage

// File: rtl/mem_access_align.sv
// Word-alignment check and word-index extraction for data-memory addresses.
module mem_access_align #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic [ADDR_W+1:0] addr_i,
    output logic              aligned_o,
    output logic [ADDR_W-1:0] word_idx_o
);

    assign aligned_o  = (addr_i[1:0] == 2'b00);
    assign word_idx_o = addr_i[ADDR_W+1:2];

endmodule

// File: rtl/mem_access.sv
// Memory stage: samples execute-stage results, runs one data-memory access, emits a writeback pulse.
module mem_access
    import mem_access_pkg::*;
#(
    parameter logic [2:0]  STATE_MEM = CU_MEM,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [2:0]        state,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              reg_write_in,
    input  logic              writef_in,
    input  logic              data_ready_in,
    input  logic [4:0]        write_reg_in,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_write_data,
    input  logic [31:0]       reg_write_data_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              reg_write_out,
    output logic              writef_out,
    output logic [4:0]        write_reg_out,
    output logic [31:0]       wb_data,
    output logic              mem_done,
    output logic              misalign
);

    mem_state_e        st_q;
    logic              reg_write_q;
    logic              writef_q;
    logic              aligned;
    logic [ADDR_W-1:0] word_idx;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^mem_addr[31:ADDR_W+2];

    mem_access_align #(
        .ADDR_W (ADDR_W)
    ) u_align (
        .addr_i     (mem_addr[ADDR_W+1:0]),
        .aligned_o  (aligned),
        .word_idx_o (word_idx)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q          <= StIdle;
            reg_write_q   <= 1'b0;
            writef_q      <= 1'b0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            reg_write_out <= 1'b0;
            writef_out    <= 1'b0;
            write_reg_out <= '0;
            wb_data       <= '0;
            mem_done      <= 1'b0;
            misalign      <= 1'b0;
        end else begin
            unique case (st_q)
                StIdle: begin
                    if (state == STATE_MEM && data_ready_in) begin
                        write_reg_out <= write_reg_in;
                        wb_data       <= reg_write_data_in;
                        if (!(mem_read_in || mem_write_in)) begin
                            st_q          <= StDone;
                            mem_done      <= 1'b1;
                            reg_write_out <= reg_write_in;
                            writef_out    <= writef_in;
                        end else if (!aligned) begin
                            // Faulting op must not commit a register write.
                            st_q          <= StDone;
                            misalign      <= 1'b1;
                            mem_done      <= 1'b1;
                            reg_write_out <= 1'b0;
                            writef_out    <= writef_in;
                        end else begin
                            st_q        <= StAccess;
                            dmem_req    <= 1'b1;
                            dmem_we     <= mem_write_in;
                            dmem_addr   <= word_idx;
                            dmem_wdata  <= mem_write_data;
                            reg_write_q <= reg_write_in;
                            writef_q    <= writef_in;
                        end
                    end
                end
                StAccess: begin
                    // Completes regardless of state; requests are never aborted.
                    if (dmem_ack) begin
                        st_q          <= StDone;
                        dmem_req      <= 1'b0;
                        dmem_we       <= 1'b0;
                        mem_done      <= 1'b1;
                        reg_write_out <= reg_write_q;
                        writef_out    <= writef_q;
                        if (!dmem_we) begin
                            wb_data <= dmem_rdata;
                        end
                    end
                end
                StDone: begin
                    st_q          <= StIdle;
                    mem_done      <= 1'b0;
                    reg_write_out <= 1'b0;
                    writef_out    <= 1'b0;
                end
                default: st_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized ops against a reference model.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  state;
    logic        mem_read_in, mem_write_in, reg_write_in, writef_in, data_ready_in;
    logic [4:0]  write_reg_in;
    logic [31:0] mem_addr, mem_write_data, reg_write_data_in;
    logic        dmem_req, dmem_we;
    logic [15:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        reg_write_out, writef_out;
    logic [4:0]  write_reg_out;
    logic [31:0] wb_data;
    logic        mem_done, misalign;

    int   checks = 0;
    int   errors = 0;
    logic misalign_exp = 1'b0;

    always #5 clk = ~clk;

    mem_access #(
        .STATE_MEM (3'd3),
        .ADDR_W    (16)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .state             (state),
        .mem_read_in       (mem_read_in),
        .mem_write_in      (mem_write_in),
        .reg_write_in      (reg_write_in),
        .writef_in         (writef_in),
        .data_ready_in     (data_ready_in),
        .write_reg_in      (write_reg_in),
        .mem_addr          (mem_addr),
        .mem_write_data    (mem_write_data),
        .reg_write_data_in (reg_write_data_in),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_ack          (dmem_ack),
        .dmem_rdata        (dmem_rdata),
        .reg_write_out     (reg_write_out),
        .writef_out        (writef_out),
        .write_reg_out     (write_reg_out),
        .wb_data           (wb_data),
        .mem_done          (mem_done),
        .misalign          (misalign)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample one op, optionally ack after `delay` extra ACCESS cycles, check the writeback pulse.
    task automatic do_op(input logic rd, input logic wr, input logic rw, input logic wf,
                         input logic [4:0] wreg, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rwdata,
                         input logic [31:0] rdata, input int delay);
        logic        is_mem;
        logic        ok;
        logic [31:0] word;
        is_mem = rd | wr;
        ok     = (addr % 4 == 0);
        word   = (addr / 4) % 65536;
        state = 3'd3; data_ready_in = 1'b1;
        mem_read_in = rd; mem_write_in = wr; reg_write_in = rw; writef_in = wf;
        write_reg_in = wreg; mem_addr = addr; mem_write_data = wdata;
        reg_write_data_in = rwdata;
        tick();
        // Scramble inputs so only latched values can reach the outputs.
        state = 3'd0; data_ready_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        reg_write_in = ~rw; writef_in = ~wf; write_reg_in = ~wreg;
        mem_addr = addr + 4; mem_write_data = ~wdata; reg_write_data_in = ~rwdata;
        if (is_mem && ok) begin
            for (int i = 0; i <= delay; i++) begin
                chk("access_req", dmem_req, 1);
                chk("access_we", dmem_we, wr);
                chk("access_addr", dmem_addr, word);
                chk("access_wdata", dmem_wdata, wdata);
                chk("access_no_done", mem_done, 0);
                if (i == delay) begin
                    dmem_ack = 1'b1; dmem_rdata = rdata;
                end
                tick();
            end
            dmem_ack = 1'b0; dmem_rdata = $urandom;
            chk("mem_done", mem_done, 1);
            chk("mem_wb_data", wb_data, wr ? rwdata : rdata);
            chk("mem_reg_write", reg_write_out, rw);
            chk("mem_writef", writef_out, wf);
            chk("mem_write_reg", write_reg_out, wreg);
            chk("mem_req_dropped", dmem_req, 0);
        end else begin
            if (is_mem) misalign_exp = 1'b1;
            chk("fast_done", mem_done, 1);
            chk("fast_no_req", dmem_req, 0);
            chk("fast_wb_data", wb_data, rwdata);
            chk("fast_reg_write", reg_write_out, is_mem ? 1'b0 : rw);
            chk("fast_writef", writef_out, wf);
            chk("fast_write_reg", write_reg_out, wreg);
        end
        chk("misalign", misalign, misalign_exp);
        tick();
        chk("done_pulse_end", mem_done, 0);
        chk("rw_gated", reg_write_out, 0);
        chk("wf_gated", writef_out, 0);
        chk("idle_no_req", dmem_req, 0);
    endtask

    initial begin
        logic        rd, wr, mis;
        logic [31:0] a;
        rstn = 1'b0; state = 3'd0; data_ready_in = 1'b0;
        mem_read_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0; writef_in = 1'b0;
        write_reg_in = '0; mem_addr = '0; mem_write_data = '0; reg_write_data_in = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        #12;
        chk("rst_req", dmem_req, 0);
        chk("rst_done", mem_done, 0);
        chk("rst_wb", wb_data, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        @(negedge clk); rstn = 1'b1;
        tick();

        // No-op, load with 3-cycle request, store with immediate ack.
        do_op(0, 0, 1, 0, 5'd5, 32'h0, 32'h0, 32'h1234, 32'h0, 0);
        do_op(1, 0, 1, 0, 5'd7, 32'h40, 32'h0, 32'h55, 32'hDEADBEEF, 2);
        do_op(0, 1, 0, 0, 5'd0, 32'h8, 32'hA5A5A5A5, 32'h99, 32'h0, 0);
        do_op(1, 1, 1, 1, 5'd9, 32'h100, 32'h0BADF00D, 32'h77, 32'h11111111, 1);

        // FPU stall: nothing sampled while data_ready_in is low.
        state = 3'd3; data_ready_in = 1'b0; reg_write_in = 1'b1; mem_read_in = 1'b1;
        mem_addr = 32'h20;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_no_done", mem_done, 0);
            chk("stall_no_req", dmem_req, 0);
        end
        do_op(0, 0, 1, 1, 5'd3, 32'h0, 32'h0, 32'hCAFE, 32'h0, 0);

        // Wrong control state and stray acks in IDLE are ignored.
        data_ready_in = 1'b1; dmem_ack = 1'b1; mem_read_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            state = 3'd4 + 3'(i);
            tick();
            chk("other_state_no_done", mem_done, 0);
            chk("other_state_no_req", dmem_req, 0);
        end
        dmem_ack = 1'b0; data_ready_in = 1'b0; state = 3'd0;

        // Misaligned load; flag stays set over idle cycles.
        do_op(1, 0, 1, 0, 5'd4, 32'h6, 32'h0, 32'h42, 32'h0, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("misalign_sticky", misalign, 1);

        for (int n = 0; n < 40; n++) begin
            rd  = 1'($urandom % 2);
            wr  = 1'($urandom % 2);
            mis = ($urandom % 6 == 0);
            a   = ($urandom & 32'hFFFF_FFFC) | (mis ? 32'($urandom % 3 + 1) : 32'h0);
            do_op(rd, wr, 1'($urandom % 2), 1'($urandom % 2), 5'($urandom),
                  a, $urandom, $urandom, $urandom, int'($urandom % 4));
        end

        // Reset in ACCESS drops the request at once; a late ack is ignored.
        state = 3'd3; data_ready_in = 1'b1; mem_read_in = 1'b1; mem_addr = 32'h80;
        reg_write_in = 1'b1;
        tick();
        state = 3'd0; data_ready_in = 1'b0; mem_read_in = 1'b0;
        chk("pre_rst_req", dmem_req, 1);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_req", dmem_req, 0);
        chk("async_rst_misalign", misalign, 0);
        chk("async_rst_wb", wb_data, 0);
        misalign_exp = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        tick();
        chk("late_ack_no_done", mem_done, 0);
        dmem_ack = 1'b0;
        tick();
        chk("late_ack_no_done2", mem_done, 0);
        chk("late_ack_no_req", dmem_req, 0);
        do_op(1, 0, 1, 0, 5'd1, 32'h4, 32'h0, 32'h0, 32'h600DD00D, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
